// File: rtl/sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo_param
// Purpose  : Single-clock parametrised FIFO used as a rate/burst buffer
//            between stream producers and consumers. It has programmable
//            almost-full/almost-empty thresholds, a selectable
//            first-word-fall-through read mode, and sticky
//            overflow/underflow error flags.
// Ports    : clk, rst (async, active-high)
//            buf_in/wr_en     - write side
//            rd_en/buf_out    - read side
//            err_clr          - synchronous clear of the sticky error flags
//            buf_empty/buf_full/buf_almost_full/buf_almost_empty - status
//            fifo_counter     - occupancy 0..DEPTH
//            overflow/underflow - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module sync_fifo_param #(
  parameter int DATA_W   = 8,   // word width, >= 1
  parameter int DEPTH    = 16,  // entries, power of two, >= 4
  parameter int AF_LEVEL = 14,  // almost-full when count >= AF_LEVEL
  parameter int AE_LEVEL = 2,   // almost-empty when count <= AE_LEVEL
  parameter int FWFT     = 0    // 0: registered read, 1: fall-through
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [DATA_W-1:0]        buf_in,
  input  logic                     wr_en,
  input  logic                     rd_en,
  input  logic                     err_clr,
  output logic [DATA_W-1:0]        buf_out,
  output logic                     buf_empty,
  output logic                     buf_full,
  output logic                     buf_almost_full,
  output logic                     buf_almost_empty,
  output logic [$clog2(DEPTH):0]   fifo_counter,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = ADDR_W + 1;

  localparam logic [CNT_W-1:0]  C_DEPTH  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  C_AF_LVL = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  C_AE_LVL = CNT_W'(AE_LEVEL);
  localparam logic [CNT_W-1:0]  C_CNT_1  = CNT_W'(1);
  localparam logic [ADDR_W-1:0] C_PTR_1  = ADDR_W'(1);

  // Storage (not reset: contents are meaningless until written)
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              ovf_q,    ovf_d;
  logic              udf_q,    udf_d;

  logic              wr_acc;
  logic              rd_acc;

  // Status flags are pure decodes of the registered count, so they move on
  // the same edge as the counter and never see wr_en/rd_en directly.
  assign buf_empty        = (cnt_q == '0);
  assign buf_full         = (cnt_q == C_DEPTH);
  assign buf_almost_full  = (cnt_q >= C_AF_LVL);
  assign buf_almost_empty = (cnt_q <= C_AE_LVL);
  assign fifo_counter     = cnt_q;
  assign overflow         = ovf_q;
  assign underflow        = udf_q;

  // Accept decisions use only registered state: no bypass through a full or
  // empty FIFO even when both requests arrive together.
  assign wr_acc = wr_en & ~buf_full;
  assign rd_acc = rd_en & ~buf_empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + C_PTR_1;
    if (rd_acc) rd_ptr_d = rd_ptr_q + C_PTR_1;

    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + C_CNT_1;
      2'b01:   cnt_d = cnt_q - C_CNT_1;
      default: cnt_d = cnt_q;
    endcase

    // Clear first so a fresh error in the same cycle wins over err_clr.
    if (err_clr) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (wr_en & buf_full)  ovf_d = 1'b1;
    if (rd_en & buf_empty) udf_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= buf_in;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word is shown combinationally; forced to zero while empty so
      // the output reads 0 out of reset and never exposes stale storage.
      assign buf_out = buf_empty ? '0 : mem_q[rd_ptr_q];
    end else begin : g_std
      logic [DATA_W-1:0] buf_out_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_out_q <= '0;
        end else if (rd_acc) begin
          buf_out_q <= mem_q[rd_ptr_q];
        end
      end

      assign buf_out = buf_out_q;
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo_param
// Purpose  : Self-checking bench for sync_fifo_param. One instance in
//            registered-read mode and one in fall-through mode share the
//            clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // Registered-read instance
  logic [7:0] din0 = '0;
  logic       wr0 = 1'b0, rd0 = 1'b0, clr0 = 1'b0;
  logic [7:0] out0;
  logic       emp0, full0, af0, ae0, ovf0, udf0;
  logic [4:0] cnt0;

  // Fall-through instance
  logic [7:0] din1 = '0;
  logic       wr1 = 1'b0, rd1 = 1'b0, clr1 = 1'b0;
  logic [7:0] out1;
  logic       emp1, full1, af1, ae1, ovf1, udf1;
  logic [4:0] cnt1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(0)
  ) u_dut0 (
    .clk(clk), .rst(rst), .buf_in(din0), .wr_en(wr0), .rd_en(rd0),
    .err_clr(clr0), .buf_out(out0), .buf_empty(emp0), .buf_full(full0),
    .buf_almost_full(af0), .buf_almost_empty(ae0), .fifo_counter(cnt0),
    .overflow(ovf0), .underflow(udf0)
  );

  sync_fifo_param #(
    .DATA_W(8), .DEPTH(16), .AF_LEVEL(14), .AE_LEVEL(2), .FWFT(1)
  ) u_dut1 (
    .clk(clk), .rst(rst), .buf_in(din1), .wr_en(wr1), .rd_en(rd1),
    .err_clr(clr1), .buf_out(out1), .buf_empty(emp1), .buf_full(full1),
    .buf_almost_full(af1), .buf_almost_empty(ae1), .fifo_counter(cnt1),
    .overflow(ovf1), .underflow(udf1)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic [7:0] e_out;
    logic [4:0] e_cnt;
    logic [5:0] e_flg;  // {empty, full, almost_full, almost_empty, ovf, udf}
  } vec_t;

  localparam int NVEC = 15;
  vec_t tbl [NVEC];

  function automatic vec_t mk(input logic wr, input logic rd, input logic clr,
                              input logic [7:0] din, input logic [7:0] e_out,
                              input logic [4:0] e_cnt, input logic [5:0] e_flg);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.din = din;
    v.e_out = e_out; v.e_cnt = e_cnt; v.e_flg = e_flg;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock on the registered-read instance; outputs sampled 1 ns after.
  task automatic cyc0(input logic wr, input logic rd, input logic clr, input logic [7:0] d);
    wr0 = wr; rd0 = rd; clr0 = clr; din0 = d;
    @(posedge clk); #1;
    wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; din0 = '0;
  endtask

  task automatic cyc1(input logic wr, input logic rd, input logic [7:0] d);
    wr1 = wr; rd1 = rd; din1 = d;
    @(posedge clk); #1;
    wr1 = 1'b0; rd1 = 1'b0; din1 = '0;
  endtask

  initial begin
    // Hand-computed vectors: 5 writes, 5 reads, underflow and err_clr rules
    tbl[0]  = mk(1, 0, 0, 8'd10, 8'd0,  5'd1, 6'b000100);
    tbl[1]  = mk(1, 0, 0, 8'd20, 8'd0,  5'd2, 6'b000100);
    tbl[2]  = mk(1, 0, 0, 8'd30, 8'd0,  5'd3, 6'b000000);
    tbl[3]  = mk(1, 0, 0, 8'd40, 8'd0,  5'd4, 6'b000000);
    tbl[4]  = mk(1, 0, 0, 8'd50, 8'd0,  5'd5, 6'b000000);
    tbl[5]  = mk(0, 1, 0, 8'd0,  8'd10, 5'd4, 6'b000000);
    tbl[6]  = mk(0, 1, 0, 8'd0,  8'd20, 5'd3, 6'b000000);
    tbl[7]  = mk(0, 1, 0, 8'd0,  8'd30, 5'd2, 6'b000100);
    tbl[8]  = mk(0, 1, 0, 8'd0,  8'd40, 5'd1, 6'b000100);
    tbl[9]  = mk(0, 1, 0, 8'd0,  8'd50, 5'd0, 6'b100100);
    tbl[10] = mk(0, 1, 0, 8'd0,  8'd50, 5'd0, 6'b100101); // read while empty
    tbl[11] = mk(0, 0, 0, 8'd0,  8'd50, 5'd0, 6'b100101); // sticky
    tbl[12] = mk(0, 0, 1, 8'd0,  8'd50, 5'd0, 6'b100100); // cleared
    tbl[13] = mk(0, 1, 1, 8'd0,  8'd50, 5'd0, 6'b100101); // set beats clear
    tbl[14] = mk(0, 0, 1, 8'd0,  8'd50, 5'd0, 6'b100100);

    // Reset: hold for two edges, release just after an edge
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_out0",  {24'd0, out0}, 32'd0);
    chk("rst_cnt0",  {27'd0, cnt0}, 32'd0);
    chk("rst_flags0", {26'd0, emp0, full0, af0, ae0, ovf0, udf0}, 32'b100100);
    chk("rst_out1",  {24'd0, out1}, 32'd0);
    chk("rst_flags1", {26'd0, emp1, full1, af1, ae1, ovf1, udf1}, 32'b100100);

    // ---- Fall-through: written word appears on the next edge ----
    cyc1(1, 0, 8'hA5);
    chk("fwft_out_a5", {24'd0, out1}, 32'hA5);
    chk("fwft_nonempty", {31'd0, emp1}, 32'd0);
    chk("fwft_cnt1", {27'd0, cnt1}, 32'd1);
    cyc1(0, 1, 8'h00);
    chk("fwft_empty_after_rd", {31'd0, emp1}, 32'd1);
    cyc1(1, 0, 8'h11);
    cyc1(1, 0, 8'h22);
    chk("fwft_head_11", {24'd0, out1}, 32'h11);
    cyc1(0, 1, 8'h00);
    chk("fwft_head_22", {24'd0, out1}, 32'h22);
    cyc1(0, 1, 8'h00);
    chk("fwft_drained", {31'd0, emp1}, 32'd1);

    // ---- Table-driven vectors on the registered-read instance ----
    for (int i = 0; i < NVEC; i++) begin
      cyc0(tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].din);
      n_chk++;
      if ({out0, cnt0, emp0, full0, af0, ae0, ovf0, udf0} !==
          {tbl[i].e_out, tbl[i].e_cnt, tbl[i].e_flg}) begin
        n_fail++;
        $display("FAIL vec%0d: out=%0d cnt=%0d flg=%b expected out=%0d cnt=%0d flg=%b",
                 i, out0, cnt0, {emp0, full0, af0, ae0, ovf0, udf0},
                 tbl[i].e_out, tbl[i].e_cnt, tbl[i].e_flg);
      end
    end

    // ---- Fill 1..16 (pointers start at 5, so this wraps) ----
    for (int k = 1; k <= 16; k++) begin
      cyc0(1, 0, 0, 8'(k));
      chk($sformatf("fill_cnt%0d", k), {27'd0, cnt0}, 32'(k));
      chk($sformatf("fill_af%0d", k), {31'd0, af0}, (k >= 14) ? 32'd1 : 32'd0);
      chk($sformatf("fill_full%0d", k), {31'd0, full0}, (k == 16) ? 32'd1 : 32'd0);
    end
    cyc0(1, 0, 0, 8'd99);
    chk("ovf_set", {31'd0, ovf0}, 32'd1);
    chk("ovf_cnt16", {27'd0, cnt0}, 32'd16);
    for (int k = 1; k <= 16; k++) begin
      cyc0(0, 1, 0, 8'd0);
      chk($sformatf("drain_out%0d", k), {24'd0, out0}, 32'(k));
    end
    chk("drain_empty", {31'd0, emp0}, 32'd1);
    chk("ovf_sticky", {31'd0, ovf0}, 32'd1);
    cyc0(0, 0, 1, 8'd0);
    chk("ovf_clr", {31'd0, ovf0}, 32'd0);

    // ---- Count 8, then simultaneous read/write for 20 cycles ----
    for (int k = 0; k < 8; k++) cyc0(1, 0, 0, 8'(100 + k));
    chk("sim_cnt8", {27'd0, cnt0}, 32'd8);
    for (int k = 0; k < 20; k++) begin
      cyc0(1, 1, 0, 8'(108 + k));
      chk($sformatf("sim_out%0d", k), {24'd0, out0}, 32'(100 + k));
      chk($sformatf("sim_cnt%0d", k), {27'd0, cnt0}, 32'd8);
    end
    for (int k = 0; k < 8; k++) begin
      cyc0(0, 1, 0, 8'd0);
      chk($sformatf("sim_tail%0d", k), {24'd0, out0}, 32'(120 + k));
    end
    chk("sim_empty", {31'd0, emp0}, 32'd1);

    // ---- Full with both requests: read wins, write dropped ----
    for (int k = 0; k < 16; k++) cyc0(1, 0, 0, 8'(200 + k));
    chk("full_before_both", {31'd0, full0}, 32'd1);
    cyc0(1, 1, 0, 8'd0);
    chk("fullboth_cnt15", {27'd0, cnt0}, 32'd15);
    chk("fullboth_ovf", {31'd0, ovf0}, 32'd1);
    chk("fullboth_out", {24'd0, out0}, 32'd200);
    cyc0(0, 0, 1, 8'd0);
    for (int k = 1; k < 16; k++) begin
      cyc0(0, 1, 0, 8'd0);
      chk($sformatf("fullboth_drain%0d", k), {24'd0, out0}, 32'(200 + k));
    end

    // ---- Empty with both requests: write wins, read rejected ----
    cyc0(1, 1, 0, 8'd77);
    chk("emptyboth_cnt1", {27'd0, cnt0}, 32'd1);
    chk("emptyboth_udf", {31'd0, udf0}, 32'd1);
    chk("emptyboth_out_hold", {24'd0, out0}, 32'd215);
    cyc0(0, 1, 1, 8'd0);
    chk("emptyboth_read77", {24'd0, out0}, 32'd77);
    chk("emptyboth_udf_clr", {31'd0, udf0}, 32'd0);

    // ---- Asynchronous reset mid-cycle with 6 words stored ----
    for (int k = 1; k <= 6; k++) cyc0(1, 0, 0, 8'(k));
    cyc0(0, 1, 0, 8'd0);
    cyc0(1, 0, 0, 8'd7);
    chk("pre_rst_cnt6", {27'd0, cnt0}, 32'd6);
    chk("pre_rst_out1", {24'd0, out0}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_cnt", {27'd0, cnt0}, 32'd0);
    chk("async_rst_empty", {31'd0, emp0}, 32'd1);
    chk("async_rst_out", {24'd0, out0}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc0(1, 0, 0, 8'h33);
    chk("post_rst_cnt1", {27'd0, cnt0}, 32'd1);
    cyc0(0, 1, 0, 8'd0);
    chk("post_rst_data", {24'd0, out0}, 32'h33);
    chk("post_rst_empty", {31'd0, emp0}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock, parametrised synchronous FIFO. It is the next generation of the team's dual-clock FIFO for paths where producer and consumer share one clock. It adds configurable width and depth, programmable almost-full/almost-empty thresholds, a selectable first-word-fall-through (FWFT) read mode, and sticky overflow/underflow error flags. It sits between stream producers and consumers in the datapath as a rate/burst buffer.

Parameters:
DATA_W, 8, data word width in bits (>=1)
DEPTH, 16, number of storage entries; power of two, >=4
AF_LEVEL, 14, buf_almost_full asserts when fifo_counter >= AF_LEVEL (1..DEPTH-1)
AE_LEVEL, 2, buf_almost_empty asserts when fifo_counter <= AE_LEVEL (1..DEPTH-1)
FWFT, 0, 0 = standard registered read; 1 = first-word-fall-through
(CNT_W = log2(DEPTH)+1, derived, not overridable)

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
buf_in  input  DATA_W  write data
wr_en  input  1  write request
rd_en  input  1  read request
err_clr  input  1  synchronous clear of overflow/underflow
buf_out  output  DATA_W  read data
buf_empty  output  1  fifo_counter == 0
buf_full  output  1  fifo_counter == DEPTH
buf_almost_full  output  1  fifo_counter >= AF_LEVEL
buf_almost_empty  output  1  fifo_counter <= AE_LEVEL
fifo_counter  output  CNT_W  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (async assert, sync release):
  - wr_ptr = rd_ptr = 0; fifo_counter = 0.
  - buf_out = 0; overflow = underflow = 0.
  - buf_empty = 1, buf_almost_empty = 1, buf_full = 0, buf_almost_full = 0.
  - Memory contents are not reset.
  - Reset mid-operation discards all stored data immediately.
- Accept rules, evaluated against registered state at the edge:
  - wr_acc = wr_en & !buf_full.
  - rd_acc = rd_en & !buf_empty.
  - No read-through-full or write-through-empty bypass.
- Pointers:
  - log2(DEPTH) bits each; natural wrap from DEPTH-1 to 0.
  - On wr_acc: mem[wr_ptr] <= buf_in and wr_ptr++.
  - On rd_acc: rd_ptr++.
- Counter:
  - +1 on wr_acc only; -1 on rd_acc only; unchanged on both or neither.
  - Never exceeds DEPTH; never goes below 0.
- Flags:
  - All four status flags are decoded from the registered fifo_counter and change on the same edge as the counter.
  - No combinational path from wr_en/rd_en to any flag.
- Read data, FWFT=0:
  - On rd_acc, buf_out <= mem[rd_ptr] at that edge (1-cycle latency).
  - Otherwise buf_out holds its last value.
- Read data, FWFT=1:
  - buf_out continuously presents mem[rd_ptr] (head word) while buf_empty = 0.
  - rd_acc pops the head; the next word (if any) is visible after that edge.
  - A word written into an empty FIFO is visible on buf_out on the edge after the write (with buf_empty deasserting).
  - buf_out is don't-care while buf_empty = 1.
- Simultaneous wr_en & rd_en:
  - Not full and not empty: both accepted; count unchanged.
  - Full: read accepted, write rejected; overflow set; count becomes DEPTH-1.
  - Empty: write accepted, read rejected; underflow set; count becomes 1.
- Errors:
  - overflow <= 1 on wr_en & buf_full; underflow <= 1 on rd_en & buf_empty.
  - Both flags are sticky until err_clr or rst.
  - If err_clr and a new error occur in the same cycle, the set wins.
  - Rejected operations never alter memory, pointers or counter.

Test Plan:
- Reset, then 5 writes (10,20,30,40,50), then 5 reads (FWFT=0):
  - buf_out = 10..50 in order, each one cycle after its rd_en edge.
  - fifo_counter goes 0→5→0; buf_empty ends 1.
- Fill to 16 writes (values 1..16):
  - buf_almost_full rises when fifo_counter reaches 14; buf_full rises at 16.
  - A 17th write sets overflow and is dropped.
  - Draining all 16 returns 1..16, and reads stay correct across the pointer wrap.
- Empty FIFO, rd_en pulse → underflow = 1, fifo_counter stays 0, buf_out unchanged. err_clr pulse → underflow = 0.
- Count 8, wr_en & rd_en held for 20 cycles with incrementing data:
  - fifo_counter stays 8 throughout; data order is preserved.
  - Full + both asserted → count 15, overflow = 1.
- FWFT=1, write 0xA5 into an empty FIFO:
  - buf_out = 0xA5 and buf_empty = 0 on the next edge, with no rd_en.
  - An rd_en pulse → buf_empty = 1.
- Count 6, rst asserted asynchronously mid-cycle:
  - fifo_counter = 0, buf_empty = 1 and buf_out = 0 immediately, without waiting for a clock edge.
  - After release, the first write/read pair returns the new data only.
